// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// elaboration-time helpers that size the chunk index.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A one-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// It also exposes the carry into its top bit so the caller can form signed overflow.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign s[gi]     = x[gi] ^ y[gi] ^ c[gi];
    assign c[gi + 1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/serial_add_n.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle through a single
// shared ripple adder, with a registered carry linking consecutive slices.
module serial_add_n
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int KW = idx_width(NCHUNK);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $fatal(1, "serial_add_n: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             carry_reg, carry_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  logic [CHUNK-1:0] chunk_x, chunk_y, chunk_s;
  logic             chunk_co, chunk_msb;

  assign chunk_x = a_reg[CHUNK*int'(k_reg) +: CHUNK];
  assign chunk_y = b_reg[CHUNK*int'(k_reg) +: CHUNK];

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .x        (chunk_x),
    .y        (chunk_y),
    .ci       (carry_reg),
    .s        (chunk_s),
    .co       (chunk_co),
    .c_msb_in (chunk_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      k_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      k_reg     <= k_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    k_next     = k_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so borrow-in becomes an inverted carry-in.
          a_next     = a;
          b_next     = sub ? ~b : b;
          carry_next = cin ^ sub;
          k_next     = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        sum_next[CHUNK*int'(k_reg) +: CHUNK] = chunk_s;
        carry_next = chunk_co;
        if (k_reg == K_LAST) begin
          cout_next  = chunk_co;
          ovf_next   = chunk_co ^ chunk_msb;
          k_next     = '0;
          state_next = DONE;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: doc/serial_add_n.md
# serial_add_n

Parametrised multi-cycle adder/subtractor that is the sequential successor of the single-bit half adder. It accepts two WIDTH-bit operands over a valid/ready handshake and adds them CHUNK bits per clock, rippling a registered carry between chunks. It returns sum, carry-out and signed overflow on a second valid/ready handshake. It sits in the arithmetic datapath wherever area matters more than latency.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per RUN cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in in add mode, borrow-in in subtract mode.
- sub  in  1  0 selects a+b+cin; 1 selects a−b−cin.
- out_valid  out  1  result is valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of the MSB; in subtract mode 1 means no borrow.
- ovf  out  1  signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- NCHUNK = WIDTH/CHUNK.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE → RUN on in_valid && in_ready.
  - Register a; register b, or ~b when sub=1.
  - Set the carry register to cin, or to !cin when sub=1.
  - Clear the chunk index k to 0.
- RUN, each cycle:
  - Add chunk k of the A register, chunk k of the B register and the carry register.
  - Write the CHUNK result bits into sum[k*CHUNK +: CHUNK].
  - Update the carry register and increment k.
- RUN → DONE on the edge that writes chunk NCHUNK−1.
  - Latch cout from that chunk's carry out.
  - Latch ovf from the MSB carry-in XOR carry-out.
- DONE → IDLE on out_ready. sum, cout and ovf hold until the next accept.
- Operands are captured at accept; a, b, cin and sub are don't-care afterwards.
- in_ready = (state==IDLE), decoded directly from the state register.
- out_valid = (state==DONE), decoded directly from the state register.
- There is no overlap: a new operation cannot be accepted in the cycle DONE is released.
- in_valid is ignored in RUN and DONE.
- Reset, including mid-RUN: state=IDLE and k=0. The in-flight operation is discarded and never reported.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry register=0.
- CHUNK=WIDTH degenerates to a single RUN cycle. The FSM is unchanged.

## Timing
- Accept edge is T.
- Chunk k is written on edge T+1+k.
- out_valid rises after edge T+NCHUNK; latency is NCHUNK cycles from accept to out_valid.
- With out_ready held high, out_valid is high for exactly 1 cycle.
- in_ready returns high the cycle after the DONE handshake.
- Best-case throughput is one operation per NCHUNK+2 cycles.
- out_valid holds indefinitely while out_ready=0. sum, cout and ovf are stable throughout.
- The critical path is one CHUNK-bit ripple add plus the carry register setup.

## Structure
- Shared package adder_pkg holds:
  - the state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the NCHUNK derivation;
  - the index width function, clog2(NCHUNK) with a minimum of 1.
- Sub-module add_chunk is a combinational CHUNK-bit ripple adder built from full-adder cells.
  - Inputs: x, y, ci.
  - Outputs: s, co, and c_msb_in (the carry into the chunk's top bit, used for ovf).
  - It is instantiated once and time-multiplexed over chunks.
- Elaboration-time check: WIDTH % CHUNK != 0 is a fatal error.

## Test plan
- WIDTH=16, CHUNK=4, a=16'h00FF, b=16'h0001, cin=0, sub=0.
  - out_valid rises 4 cycles after accept.
  - sum=16'h0100, cout=0, ovf=0.
- a=16'h7FFF, b=16'h0001, add.
  - sum=16'h8000, cout=0, ovf=1.
- a=16'h0003, b=16'h0005, sub=1, cin=0.
  - sum=16'hFFFE, cout=0 (borrow), ovf=0.
- a=16'hFFFF, b=16'h0001, cin=1, add.
  - sum=16'h0001, cout=1, ovf=0.
- Hold out_ready=0 for 10 cycles after DONE.
  - out_valid and sum stay stable; in_ready stays 0; a second in_valid is not accepted.
  - Release out_ready: in_ready=1 on the next cycle.
- Assert rst_n=0 asynchronously at the second RUN cycle, then release.
  - out_valid=0 and sum=0 immediately on reset.
  - No result is produced for the aborted operation.
  - A following operation 16'h1234+16'h1111 yields 16'h2345.
